riscv_main_datapath: RTL and testbench



---
 rtl/riscv_main_datapath_pkg.sv | 53 +++++
 rtl/riscv_main_datapath_if.sv | 8 +
 rtl/riscv_control_unit.sv | 62 ++++++
 rtl/riscv_main_datapath.sv | 137 +++++++++++++
 tb/tb_riscv_main_datapath.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_main_datapath_pkg.sv
// Shared types and constants for the single-cycle RV64I subset datapath.
package riscv_main_datapath_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned PATCH_WORDS = 8;
  localparam int unsigned PATCH_BASE  = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // Power-on / reset contents of the data memory.
  function automatic logic [XLEN-1:0] dmem_init(input int unsigned idx);
    case (idx)
      0:       return XLEN'(15);
      5:       return XLEN'(25);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_main_datapath_if.sv
// PC loop between the external PC register (master) and the datapath (slave).
interface riscv_main_datapath_if;
  logic [riscv_main_datapath_pkg::XLEN-1:0] pc;
  logic [riscv_main_datapath_pkg::XLEN-1:0] pc_next;

  modport master (output pc, input pc_next);
  modport slave  (input pc, output pc_next);
endinterface

// File: rtl/riscv_control_unit.sv
// Main decoder: opcode/funct fields to datapath control; unknown encodings decode as NOP.
module riscv_control_unit
  import riscv_main_datapath_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (opcode)
      OP_R: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_op    = ALU_ADD;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_op    = ALU_SUB;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_op    = ALU_AND;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_op    = ALU_OR;
        end
      end
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_src   = 1'b1;
          ctrl_c.alu_op    = ALU_ADD;
        end
      end
      OP_LOAD: begin
        if (funct3 == F3_DWORD) begin
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.alu_src    = 1'b1;
          ctrl_c.mem_read   = 1'b1;
          ctrl_c.mem_to_reg = 1'b1;
          ctrl_c.alu_op     = ALU_ADD;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_DWORD) begin
          ctrl_c.alu_src   = 1'b1;
          ctrl_c.mem_write = 1'b1;
          ctrl_c.alu_op    = ALU_ADD;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          ctrl_c.branch = 1'b1;
          ctrl_c.alu_op = ALU_SUB;
        end
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/riscv_main_datapath.sv
// Single-cycle RV64I subset core: ROM fetch, decode, regfile, ALU, data memory, next-PC.
module riscv_main_datapath
  import riscv_main_datapath_pkg::*;
#(
  parameter int unsigned                  IMEM_WORDS = 64,
  parameter int unsigned                  DMEM_WORDS = 32,
  parameter logic [PATCH_WORDS*ILEN-1:0]  IMEM_PATCH = {PATCH_WORDS{INSN_NOP}}
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_main_datapath_if.slave bus
);

  localparam int unsigned DMEM_AW  = $clog2(DMEM_WORDS);
  localparam int unsigned PATCH_IW = $clog2(PATCH_WORDS * ILEN);

  logic [7:0]      imem_idx;
  logic [ILEN-1:0] instr;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [DMEM_AW-1:0] dmem_idx;
  logic [XLEN-1:0] dmem_rdata;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic            unused_pc_bits;

  assign imem_idx       = bus.pc[9:2];
  assign unused_pc_bits = ^{bus.pc[XLEN-1:10], bus.pc[1:0]};

  // Fixed demo program; words 8.. may be overridden through IMEM_PATCH.
  always_comb begin
    instr = INSN_NOP;
    case (imem_idx)
      8'd1: instr = 32'h0000_0293;  // addi x5,x0,0
      8'd2: instr = 32'h0050_0513;  // addi x10,x0,5
      8'd3: instr = 32'h00A0_0593;  // addi x11,x0,10
      8'd4: instr = 32'h0002_B303;  // ld   x6,0(x5)
      8'd5: instr = 32'h0005_3383;  // ld   x7,0(x10)
      8'd6: instr = 32'h0073_0433;  // add  x8,x6,x7
      8'd7: instr = 32'h0085_B023;  // sd   x8,0(x11)
      default: begin
        for (int unsigned i = 0; i < PATCH_WORDS; i++) begin
          if (32'(imem_idx) == PATCH_BASE + i)
            instr = IMEM_PATCH[PATCH_IW'(i * ILEN) +: ILEN];
        end
      end
    endcase
    if (32'(imem_idx) >= IMEM_WORDS)
      instr = INSN_NOP;
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  riscv_control_unit u_ctrl (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .ctrl_c (ctrl)
  );

  // Sign-extended I/S/B immediates; B carries the implicit zero LSB.
  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:       imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
      default:         imm = '0;
    endcase
  end

  // Reads see the pre-edge value; no write-through bypass.
  assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];

  always_comb begin
    alu_b      = ctrl.alu_src ? imm : rs2_data;
    alu_result = '0;
    case (ctrl.alu_op)
      ALU_ADD: alu_result = rs1_data + alu_b;
      ALU_SUB: alu_result = rs1_data - alu_b;
      ALU_AND: alu_result = rs1_data & alu_b;
      ALU_OR:  alu_result = rs1_data | alu_b;
      default: alu_result = '0;
    endcase
  end

  assign zero       = (alu_result == '0);
  assign dmem_idx   = DMEM_AW'(alu_result % XLEN'(DMEM_WORDS));
  assign dmem_rdata = ctrl.mem_read ? dmem[dmem_idx] : '0;
  assign wb_data    = ctrl.mem_to_reg ? dmem_rdata : alu_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (ctrl.reg_write && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++)
        dmem[i] <= dmem_init(i);
    end else if (ctrl.mem_write) begin
      dmem[dmem_idx] <= rs2_data;
    end
  end

  always_comb begin
    bus.pc_next = bus.pc + XLEN'(4);
    if (!reset)
      bus.pc_next = XLEN'(4);
    else if (ctrl.branch && zero)
      bus.pc_next = bus.pc + imm;
  end

endmodule

// File: tb/tb_riscv_main_datapath.sv
// Directed bench for riscv_main_datapath with an instruction-level reference model.
module tb_riscv_main_datapath;
  import riscv_main_datapath_pkg::*;

  localparam logic [31:0] W_NOP     = 32'h0000_0013;
  localparam logic [31:0] W_BEQ_X0  = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] W_BEQ_X8  = 32'hFE04_0CE3;  // beq x8,x0,-8
  localparam logic [31:0] W_ADDI_X0 = 32'h0070_0013;  // addi x0,x0,7
  localparam logic [31:0] W_ADD_X0  = 32'h00B5_0033;  // add x0,x10,x11
  localparam logic [31:0] W_SUB     = 32'h40B5_04B3;  // sub x9,x10,x11
  localparam logic [31:0] W_OR      = 32'h00B5_66B3;  // or  x13,x10,x11
  localparam logic [31:0] W_AND     = 32'h00B6_F633;  // and x12,x13,x11
  localparam logic [31:0] W_LUI     = 32'h0000_1737;  // lui x14,1 (unsupported)
  localparam logic [8*32-1:0] PATCH =
    {W_LUI, W_AND, W_OR, W_SUB, W_ADD_X0, W_ADDI_X0, W_BEQ_X8, W_BEQ_X0};

  logic clk;
  logic reset;
  riscv_main_datapath_if bus ();

  riscv_main_datapath #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (32),
    .IMEM_PATCH (PATCH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_dmem [32];
  logic [31:0] m_imem [64];
  bit          p_rst, p_rw, p_mw;
  int          p_rd, p_midx;
  logic [63:0] p_rval, p_mval;
  logic [63:0] seen_pc_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset_state();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_dmem[i] = '0;
    end
    m_dmem[0] = 64'd15;
    m_dmem[5] = 64'd25;
  endtask

  // Executes one instruction at ISA level; results are held until the clock edge.
  task automatic model_eval(input logic [63:0] p, input logic r, output logic [63:0] npc);
    logic [31:0] w;
    logic [63:0] a, b, ii, is, ib;
    int rs1, rs2;
    w   = (p[9:2] < 8'd64) ? m_imem[int'(p[7:2])] : W_NOP;
    rs1 = int'(w[19:15]);
    rs2 = int'(w[24:20]);
    a   = (rs1 == 0) ? 64'd0 : m_regs[rs1];
    b   = (rs2 == 0) ? 64'd0 : m_regs[rs2];
    ii  = {{52{w[31]}}, w[31:20]};
    is  = {{52{w[31]}}, w[31:25], w[11:7]};
    ib  = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    npc = p + 64'd4;
    p_rst = 0; p_rw = 0; p_mw = 0; p_rd = int'(w[11:7]); p_midx = 0;
    p_rval = '0; p_mval = '0;
    if (!r) begin
      npc   = 64'd4;
      p_rst = 1;
    end else if (w[6:0] == 7'b0110011) begin
      p_rw = 1;
      if      (w[14:12] == 3'd0 && w[31:25] == 7'h00) p_rval = a + b;
      else if (w[14:12] == 3'd0 && w[31:25] == 7'h20) p_rval = a - b;
      else if (w[14:12] == 3'd7 && w[31:25] == 7'h00) p_rval = a & b;
      else if (w[14:12] == 3'd6 && w[31:25] == 7'h00) p_rval = a | b;
      else p_rw = 0;
    end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'd0) begin
      p_rw = 1; p_rval = a + ii;
    end else if (w[6:0] == 7'b0000011 && w[14:12] == 3'd3) begin
      p_rw = 1; p_rval = m_dmem[int'((a + ii) % 64'd32)];
    end else if (w[6:0] == 7'b0100011 && w[14:12] == 3'd3) begin
      p_mw = 1; p_midx = int'((a + is) % 64'd32); p_mval = b;
    end else if (w[6:0] == 7'b1100011 && w[14:12] == 3'd0) begin
      if (a == b) npc = p + ib;
    end
  endtask

  task automatic model_commit();
    if (p_rst) model_reset_state();
    else begin
      if (p_rw && p_rd != 0) m_regs[p_rd] = p_rval;
      if (p_mw) m_dmem[p_midx] = p_mval;
    end
  endtask

  // One clock period: drive, compare everything at the falling edge, commit at the rising edge.
  task automatic cycle(input logic [63:0] p, input logic r, input bit use_lit, input logic [63:0] lit);
    logic [63:0] npc;
    bus.pc = p;
    reset  = r;
    @(negedge clk);
    model_eval(p, r, npc);
    seen_pc_next = bus.pc_next;
    chk($sformatf("pc_next@%0h", p), bus.pc_next, npc);
    if (use_lit) chk($sformatf("pc_next_lit@%0h", p), bus.pc_next, lit);
    for (int i = 1; i < 32; i++) chk($sformatf("x%0d", i), dut.regs[i], m_regs[i]);
    for (int i = 0; i < 32; i++) chk($sformatf("dmem[%0d]", i), dut.dmem[i], m_dmem[i]);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    logic [63:0] p;
    for (int i = 0; i < 64; i++) m_imem[i] = W_NOP;
    m_imem[1] = 32'h0000_0293; m_imem[2] = 32'h0050_0513; m_imem[3] = 32'h00A0_0593;
    m_imem[4] = 32'h0002_B303; m_imem[5] = 32'h0005_3383; m_imem[6] = 32'h0073_0433;
    m_imem[7] = 32'h0085_B023;
    m_imem[8]  = W_BEQ_X0;  m_imem[9]  = W_BEQ_X8; m_imem[10] = W_ADDI_X0;
    m_imem[11] = W_ADD_X0;  m_imem[12] = W_SUB;    m_imem[13] = W_OR;
    m_imem[14] = W_AND;     m_imem[15] = W_LUI;
    model_reset_state();
    reset  = 1'b0;
    bus.pc = 64'd4;
    @(posedge clk);
    #1;

    // Reset held for two edges
    cycle(64'd4, 1'b0, 1, 64'd4);
    cycle(64'd4, 1'b0, 1, 64'd4);
    for (int i = 5; i <= 11; i++) chk($sformatf("rst_x%0d", i), dut.regs[i], 64'd0);
    chk("rst_dmem10", dut.dmem[10], 64'd0);

    // Sequential flow through the demo program, PC fed back from pc_next
    p = 64'd4;
    for (int k = 0; k < 7; k++) begin
      cycle(p, 1'b1, 1, 64'd8 + 64'(4 * k));
      p = seen_pc_next;
    end
    chk("prog_x5",  dut.regs[5],  64'd0);
    chk("prog_x10", dut.regs[10], 64'd5);
    chk("prog_x11", dut.regs[11], 64'd10);
    chk("prog_x6",  dut.regs[6],  64'd15);
    chk("prog_x7",  dut.regs[7],  64'd25);
    chk("prog_x8",  dut.regs[8],  64'd40);
    chk("prog_dmem10", dut.dmem[10], 64'd40);

    // Branch taken, branch not taken, x0 writes, ALU ops, unsupported opcode
    cycle(64'd32, 1'b1, 1, 64'd24);
    cycle(64'd36, 1'b1, 1, 64'd40);
    cycle(64'd40, 1'b1, 1, 64'd44);
    cycle(64'd44, 1'b1, 1, 64'd48);
    cycle(64'd48, 1'b1, 1, 64'd52);
    cycle(64'd52, 1'b1, 1, 64'd56);
    cycle(64'd56, 1'b1, 1, 64'd60);
    cycle(64'd60, 1'b1, 1, 64'd64);
    cycle(64'd0,  1'b1, 1, 64'd4);
    bus.pc = 64'd32;
    #1;
    chk("x0_read", dut.rs1_data, 64'd0);
    chk("sub_x9",  dut.regs[9],  64'hFFFF_FFFF_FFFF_FFFB);
    chk("or_x13",  dut.regs[13], 64'd15);
    chk("and_x12", dut.regs[12], 64'd10);
    chk("lui_x14", dut.regs[14], 64'd0);

    // Reset mid-program after ld x6 retires
    cycle(64'd4, 1'b0, 1, 64'd4);
    for (int a = 4; a <= 16; a += 4) cycle(64'(a), 1'b1, 1, 64'(a + 4));
    chk("mid_x6_loaded", dut.regs[6], 64'd15);
    cycle(64'd20, 1'b0, 1, 64'd4);
    chk("mid_x6_cleared", dut.regs[6], 64'd0);
    chk("mid_x10", dut.regs[10], 64'd0);
    cycle(64'd20, 1'b0, 1, 64'd4);
    cycle(64'd36, 1'b1, 1, 64'd28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
